// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: per channel a 2-flop synchroniser, a 4-state
// debounce FSM, press/release/long-press pulses and a press-toggled level.
module multi_debouncer #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter bit ACTIVE_LOW_IN   = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_CH-1:0]     i_bouncy_switch,
    input  logic [NUM_CH-1:0]     i_toggle_clr,
    output logic [NUM_CH-1:0]     o_clean_switch,
    output logic [NUM_CH-1:0]     o_press,
    output logic [NUM_CH-1:0]     o_release,
    output logic [NUM_CH-1:0]     o_long,
    output logic [NUM_CH-1:0]     o_toggle,
    output logic [2*NUM_CH-1:0]   o_dbg_state
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [NUM_CH-1:0] INV_MASK = ACTIVE_LOW_IN ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [1:0]        rst_pipe;
    logic              run;
    logic [NUM_CH-1:0] sync_meta;
    logic [NUM_CH-1:0] sync_q;

    state_t            state_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [HOLD_W-1:0] hold_q  [NUM_CH];

    // Reset release is pipelined so every channel leaves reset on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign run = rst_pipe[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= i_bouncy_switch ^ INV_MASK;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            o_clean_switch <= '0;
            o_press        <= '0;
            o_release      <= '0;
            o_long         <= '0;
            o_toggle       <= '0;
        end else begin
            o_press   <= '0;
            o_release <= '0;
            o_long    <= '0;
            if (run) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    // Hold timing keeps running through RELEASE_CHK so a bounce cannot restart it.
                    if ((LONG_CYCLES != 0) &&
                        ((state_q[i] == PRESSED) || (state_q[i] == RELEASE_CHK)) &&
                        (hold_q[i] != HOLD_MAX)) begin
                        hold_q[i] <= hold_q[i] + 1'b1;
                        if (hold_q[i] == HOLD_MAX - 1'b1) begin
                            o_long[i] <= 1'b1;
                        end
                    end

                    if (i_toggle_clr[i]) begin
                        o_toggle[i] <= 1'b0;
                    end

                    case (state_q[i])
                        RELEASED: begin
                            if (sync_q[i]) begin
                                state_q[i] <= PRESS_CHK;
                                cnt_q[i]   <= '0;
                            end
                        end
                        PRESS_CHK: begin
                            if (!sync_q[i]) begin
                                state_q[i] <= RELEASED;
                                cnt_q[i]   <= '0;
                            end else if (cnt_q[i] == CNT_LAST) begin
                                state_q[i]        <= PRESSED;
                                cnt_q[i]          <= '0;
                                hold_q[i]         <= '0;
                                o_clean_switch[i] <= 1'b1;
                                o_press[i]        <= 1'b1;
                                o_toggle[i]       <= i_toggle_clr[i] ? 1'b1 : ~o_toggle[i];
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                        PRESSED: begin
                            if (!sync_q[i]) begin
                                state_q[i] <= RELEASE_CHK;
                                cnt_q[i]   <= '0;
                            end
                        end
                        RELEASE_CHK: begin
                            if (sync_q[i]) begin
                                state_q[i] <= PRESSED;
                                cnt_q[i]   <= '0;
                            end else if (cnt_q[i] == CNT_LAST) begin
                                state_q[i]        <= RELEASED;
                                cnt_q[i]          <= '0;
                                o_clean_switch[i] <= 1'b0;
                                o_release[i]      <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                        default: begin
                            state_q[i] <= RELEASED;
                            cnt_q[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        o_dbg_state = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            o_dbg_state[2*i +: 2] = state_q[i];
        end
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios followed by random switching,
// all compared against a run-length reference model of the debounce rules.
module tb_multi_debouncer;

    localparam int NCH = 2;
    localparam int D   = 4;
    localparam int L   = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   sw  = '0;
    logic [NCH-1:0]   clr = '0;
    logic [NCH-1:0]   clean, press, rel, lng, tog;
    logic [2*NCH-1:0] dbg;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NCH-1:0] m_s1, m_s2, m_clean, m_press, m_rel, m_long, m_tog;
    int             m_run  [NCH];
    int             m_held [NCH];

    multi_debouncer #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW_IN(1'b0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_bouncy_switch(sw), .i_toggle_clr(clr),
        .o_clean_switch(clean), .o_press(press), .o_release(rel), .o_long(lng),
        .o_toggle(tog), .o_dbg_state(dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_press = '0;
        m_rel = '0; m_long = '0; m_tog = '0;
        for (int i = 0; i < NCH; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    // A level change is accepted once D+1 consecutive synchronised samples
    // disagree with the current clean level.
    task automatic model_edge();
        logic s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            s       = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = sw[i];
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_long[i]  = 1'b0;
            if (m_clean[i]) begin
                m_held[i]++;
                if (L > 0 && m_held[i] == L) m_long[i] = 1'b1;
            end
            if (s != m_clean[i]) m_run[i]++;
            else m_run[i] = 0;
            if (clr[i]) m_tog[i] = 1'b0;
            if (m_run[i] == D + 1) begin
                m_run[i]   = 0;
                m_clean[i] = ~m_clean[i];
                if (m_clean[i]) begin
                    m_press[i] = 1'b1;
                    m_held[i]  = 0;
                    m_tog[i]   = clr[i] ? 1'b1 : ~m_tog[i];
                end else begin
                    m_rel[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("clean",   clean, m_clean);
        chk("press",   press, m_press);
        chk("release", rel,   m_rel);
        chk("long",    lng,   m_long);
        chk("toggle",  tog,   m_tog);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until the selected pulse appears on channel ch, bounded at 40 edges.
    task automatic wait_pulse(input int ch, input bit want_rel, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((want_rel ? rel[ch] : press[ch]) !== 1'b1) && n < 40);
    endtask

    initial begin
        int n;
        int first_long;
        int long_cnt;
        int exp_tog [3];
        exp_tog = '{1, 0, 1};

        // Reset state
        model_reset();
        #1;
        compare_all();
        chk("reset_dbg", dbg[NCH-1:0], '0);
        steps(3);
        rst_n = 1'b1;
        steps(4);

        // Clean press on ch0: latency D+2 after the capturing edge, one-cycle pulse
        sw[0] = 1'b1;
        wait_pulse(0, 1'b0, n);
        chk_int("press_latency", n, D + 3);
        chk_int("clean_at_press", int'(clean[0]), 1);
        step();
        chk_int("press_one_cycle", int'(press[0]), 0);

        // Plain release of ch0
        sw[0] = 1'b0;
        wait_pulse(0, 1'b1, n);
        chk_int("release_latency", n, D + 3);
        steps(6);

        // Bounce reject: 3 high cycles on ch0
        n = 0;
        sw[0] = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j == 3) sw[0] = 1'b0;
            step();
            if (press[0] === 1'b1 || clean[0] === 1'b1) n++;
        end
        chk_int("bounce_no_press", n, 0);

        // Long press on ch1 with one bounce during the hold
        sw[1] = 1'b1;
        wait_pulse(1, 1'b0, n);
        chk_int("ch1_press_latency", n, D + 3);
        first_long = -1;
        long_cnt   = 0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 4) sw[1] = 1'b0;
            if (j == 5) sw[1] = 1'b1;
            step();
            if (lng[1] === 1'b1) begin
                long_cnt++;
                if (first_long < 0) first_long = j;
            end
        end
        chk_int("long_offset", first_long, L);
        chk_int("long_count", long_cnt, 1);
        sw[1] = 1'b0;
        wait_pulse(1, 1'b1, n);
        steps(6);

        // Toggle sequence on ch0
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            sw[0] = 1'b1;
            wait_pulse(0, 1'b0, n);
            chk_int("toggle_seq", int'(tog[0]), exp_tog[j]);
            sw[0] = 1'b0;
            wait_pulse(0, 1'b1, n);
            steps(4);
        end
        sw[0] = 1'b1;
        steps(D + 2);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk_int("clr_with_press_pulse", int'(press[0]), 1);
        chk_int("clr_with_press_toggle", int'(tog[0]), 1);
        steps(3);

        // Release delayed by a one-cycle re-high during RELEASE_CHK
        sw[0] = 1'b0;
        steps(2);
        sw[0] = 1'b1;
        step();
        sw[0] = 1'b0;
        wait_pulse(0, 1'b1, n);
        chk_int("release_delayed", n + 3, D + 6);
        steps(6);

        // Reset while ch1 is in PRESS_CHK
        sw[1] = 1'b1;
        steps(4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("reset_mid_dbg", dbg[NCH-1:0], '0);
        steps(2);
        rst_n = 1'b1;
        wait_pulse(1, 1'b0, n);
        chk_int("reaccept_after_reset", n, D + 3);
        steps(3);

        // Random switching with alternating bounce rates
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, ((c / 100) % 2 == 1) ? 4 : 18) == 0) sw[i] = ~sw[i];
                clr[i] = ($urandom_range(0, 9) == 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
